// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the traffic light controller: state codes, parameter
// select codes, {R,Y,G} lamp encodings and default interval lengths.
package traffic_light_fsm_pkg;

    typedef enum logic [2:0] {
        S_MG1 = 3'd0,
        S_MG2 = 3'd1,
        S_MY  = 3'd2,
        S_WLK = 3'd3,
        S_SG  = 3'd4,
        S_SY  = 3'd5
    } state_t;

    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_YEL  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam int DEF_BASE = 6;
    localparam int DEF_EXT  = 3;
    localparam int DEF_YEL  = 2;

    function automatic logic [2:0] main_light(input state_t s);
        case (s)
            S_MG1, S_MG2: main_light = LIGHT_G;
            S_MY:         main_light = LIGHT_Y;
            default:      main_light = LIGHT_R;
        endcase
    endfunction

    function automatic logic [2:0] side_light(input state_t s);
        case (s)
            S_SG:    side_light = LIGHT_G;
            S_SY:    side_light = LIGHT_Y;
            default: side_light = LIGHT_R;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_fsm_interval_timer.sv
// Tick counter with expiry compare; restarts itself on expiry since every
// expiry either changes state or starts the side-green extension.
module interval_timer (
    input  logic       clk,
    input  logic       Reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [3:0] interval,
    output logic       expire
);

    logic [3:0] r_count;

    // interval is never 0, so interval-1 cannot wrap
    assign expire = tick && (r_count == (interval - 4'd1));

    always_ff @(posedge clk) begin
        if (Reset || clear || expire) begin
            r_count <= 4'd0;
        end else if (tick) begin
            r_count <= r_count + 4'd1;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side street traffic light controller with sensor extension, pedestrian
// walk phase and run-time reprogrammable interval lengths.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int P_BASE = DEF_BASE,
    parameter int P_EXT  = DEF_EXT,
    parameter int P_YEL  = DEF_YEL
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sensor,
    input  logic       WalkReq,
    input  logic       Reprogram,
    input  logic [1:0] ParamSel,
    input  logic [3:0] ParamVal,
    input  logic       Tick,
    output logic [2:0] MainLight,
    output logic [2:0] SideLight,
    output logic       Walk
);

    localparam logic [3:0] L_BASE = 4'(P_BASE);
    localparam logic [3:0] L_EXT  = 4'(P_EXT);
    localparam logic [3:0] L_YEL  = 4'(P_YEL);

    state_t     r_state;
    logic [3:0] r_tbase;
    logic [3:0] r_text;
    logic [3:0] r_tyel;
    logic       r_walk_pend;
    logic       r_mg2_ext;
    logic       r_sg_ext;

    state_t     w_state_nxt;
    logic [3:0] w_tbase_nxt;
    logic [3:0] w_text_nxt;
    logic [3:0] w_tyel_nxt;
    logic       w_walk_pend_nxt;
    logic       w_mg2_ext_nxt;
    logic       w_sg_ext_nxt;
    logic [3:0] w_interval;
    logic       w_expire;
    logic       w_prog_ok;

    assign w_prog_ok = Reprogram && (ParamSel != SEL_NONE) && (ParamVal != 4'd0);

    // MG2 and SG lengths depend on the sensor decision taken when they began
    always_comb begin
        case (r_state)
            S_MG1:   w_interval = r_tbase;
            S_MG2:   w_interval = r_mg2_ext ? r_text : r_tbase;
            S_MY:    w_interval = r_tyel;
            S_WLK:   w_interval = r_text;
            S_SG:    w_interval = r_sg_ext ? r_text : r_tbase;
            S_SY:    w_interval = r_tyel;
            default: w_interval = r_tbase;
        endcase
    end

    interval_timer u_timer (
        .clk      (clk),
        .Reset    (Reset),
        .clear    (w_prog_ok),
        .tick     (Tick),
        .interval (w_interval),
        .expire   (w_expire)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_tbase_nxt     = r_tbase;
        w_text_nxt      = r_text;
        w_tyel_nxt      = r_tyel;
        w_walk_pend_nxt = r_walk_pend | WalkReq;
        w_mg2_ext_nxt   = r_mg2_ext;
        w_sg_ext_nxt    = r_sg_ext;

        if (w_prog_ok) begin
            w_state_nxt     = S_MG1;
            w_walk_pend_nxt = 1'b0;
            w_sg_ext_nxt    = 1'b0;
            case (ParamSel)
                SEL_BASE: w_tbase_nxt = ParamVal;
                SEL_EXT:  w_text_nxt  = ParamVal;
                SEL_YEL:  w_tyel_nxt  = ParamVal;
                default:  w_tbase_nxt = r_tbase;
            endcase
        end else if (w_expire) begin
            case (r_state)
                S_MG1: begin
                    w_state_nxt   = S_MG2;
                    w_mg2_ext_nxt = Sensor;
                end
                S_MG2: w_state_nxt = S_MY;
                S_MY: begin
                    if (r_walk_pend) begin
                        w_state_nxt     = S_WLK;
                        w_walk_pend_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = S_SG;
                        w_sg_ext_nxt = 1'b0;
                    end
                end
                S_WLK: begin
                    w_state_nxt  = S_SG;
                    w_sg_ext_nxt = 1'b0;
                end
                S_SG: begin
                    if (!r_sg_ext && Sensor) begin
                        w_sg_ext_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_SY;
                        w_sg_ext_nxt = 1'b0;
                    end
                end
                S_SY:    w_state_nxt = S_MG1;
                default: w_state_nxt = S_MG1;
            endcase
        end
    end

    // Lamps decode the next state so they switch on the same edge as the state
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= S_MG1;
            r_tbase     <= L_BASE;
            r_text      <= L_EXT;
            r_tyel      <= L_YEL;
            r_walk_pend <= 1'b0;
            r_mg2_ext   <= 1'b0;
            r_sg_ext    <= 1'b0;
            MainLight   <= LIGHT_G;
            SideLight   <= LIGHT_R;
            Walk        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tbase     <= w_tbase_nxt;
            r_text      <= w_text_nxt;
            r_tyel      <= w_tyel_nxt;
            r_walk_pend <= w_walk_pend_nxt;
            r_mg2_ext   <= w_mg2_ext_nxt;
            r_sg_ext    <= w_sg_ext_nxt;
            MainLight   <= main_light(w_state_nxt);
            SideLight   <= side_light(w_state_nxt);
            Walk        <= (w_state_nxt == S_WLK);
        end
    end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameter P_BASE, default 6, main/side green base interval in ticks.
REQ-002 SHALL have parameter P_EXT, default 3, extension and walk interval in ticks.
REQ-003 SHALL have parameter P_YEL, default 2, yellow interval in ticks.
REQ-004 SHALL have port clk  input  1  sole clock; every flop uses its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset, driven by Sync_Reset from the synchronizer stage.
REQ-006 SHALL have port Sensor  input  1  side-street vehicle present, already synchronized.
REQ-007 SHALL have port WalkReq  input  1  pedestrian request, already synchronized, level.
REQ-008 SHALL have port Reprogram  input  1  one-cycle write strobe for timing parameters, already synchronized.
REQ-009 SHALL have port ParamSel  input  2  0=base, 1=ext, 2=yellow, 3=no effect.
REQ-010 SHALL have port ParamVal  input  4  new interval value in ticks.
REQ-011 SHALL have port Tick  input  1  one-cycle 1 Hz enable; all timing counts Tick pulses.
REQ-012 SHALL have ports MainLight and SideLight  output  3 each  {R,Y,G} one-hot, registered.
REQ-013 SHALL have port Walk  output  1  walk lamp, registered.

Function
REQ-014 SHALL implement states MG1, MG2, MY, WLK, SG, SY; lights: MG1/MG2 main G side R; MY main Y side R; WLK both R, Walk=1; SG main R side G; SY main R side Y.
REQ-015 Outputs SHALL be a registered decode of the current state, so they change on the same edge as the state.
REQ-016 The interval counter SHALL clear on every state change and increment on each Tick; a state expires on the edge where Tick=1 and count == interval-1.
REQ-017 Intervals: MG1=tBASE; MG2=tBASE, or tEXT if Sensor=1 on the MG1 expiry edge; MY=tYEL; WLK=tEXT; SG=tBASE, extended once by tEXT if Sensor=1 on the SG base expiry edge; SY=tYEL.
REQ-018 Transitions: MG1->MG2->MY; MY->WLK if walk_pending else SG; WLK->SG; SG->SY->MG1.
REQ-019 walk_pending SHALL set on any cycle with WalkReq=1 and clear on the MY->WLK edge; WalkReq=1 on that same edge SHALL leave it cleared (request served).
REQ-020 On Reprogram=1 with ParamSel<3 and ParamVal!=0, the selected register SHALL load ParamVal on that edge; ParamVal=0 or ParamSel=3 SHALL leave all registers unchanged.
REQ-021 Any accepted Reprogram SHALL force state MG1, clear the counter, and clear walk_pending on the same edge.
REQ-022 Interval registers SHALL be 4 bits wide (1..15 ticks); comparisons SHALL not wrap.
REQ-023 Tick=0 SHALL freeze the counter; state SHALL never change without Tick except on Reset or Reprogram.

Reset
REQ-024 Reset=1 at an edge SHALL force state MG1, counter 0, walk_pending 0, tBASE/tEXT/tYEL=P_BASE/P_EXT/P_YEL, MainLight=001, SideLight=100, Walk=0.
REQ-025 Reset SHALL take priority over Reprogram, Tick and WalkReq, including mid-interval and in WLK.

Structure
REQ-026 A shared package SHALL hold the state enumeration, the ParamSel codes, the {R,Y,G} light encodings and the default interval constants.
REQ-027 The counter and expiry compare SHALL be one sub-module, interval_timer (inputs: clear, tick, interval; output: expire).

Verification
REQ-028 Tick every cycle, Sensor=0, WalkReq=0 after Reset -> MG1 6, MG2 6, MY 2, SG 6, SY 2 cycles, then MG1; period 22.
REQ-029 Sensor=1 throughout -> MG2 lasts 3 and SG lasts 6+3=9.
REQ-030 WalkReq pulse in MG1 -> after MY, WLK for 3 cycles with Walk=1 and both R, then SG; the next cycle skips WLK.
REQ-031 Reprogram with ParamSel=2, ParamVal=5 during SG -> immediate MG1, later MY lasts 5; ParamVal=0 -> no change, no restart.
REQ-032 Reset asserted in WLK simultaneous with Reprogram and WalkReq -> next edge MG1, defaults restored, walk_pending=0.
REQ-033 Tick held 0 for 50 cycles in MG2 -> lights frozen; timing resumes on the first Tick.
